// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer.
//   seq_state_t : encoded FSM state, also driven out on state_o for debug LEDs
//   COUNT_W     : width of the datapath counter value
package count_seq_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MANUAL    = 2'd1,
    AUTO      = 2'd2,
    CELEBRATE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample debouncer and rising-edge pulse.
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   button_raw_i in   unsynchronised button, high = pressed
//   press_evt_o  out  1-cycle pulse when a debounced 0->1 level change is accepted
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw_i,
  output logic press_evt_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // The counter tracks how many consecutive samples have differed from the accepted level;
  // any sample that agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_evt_o = press_q;

endmodule

// File: rtl/count_sequencer_ctrl.sv
// Sequencer for the 0..COUNT_MAX display counter. Converts button presses (manual) or an
// internal tick (auto) into single-cycle increment/clear commands and holds off in a
// celebrate phase while the LED animation plays. Owns no count register.
//   clk, reset    clock; asynchronous active-high reset
//   button_raw    unsynchronised push-button, high = pressed
//   run           0 forces IDLE and holds the counter cleared
//   mode_sel      0 = manual (button), 1 = auto (tick)
//   count         current counter value from the datapath
//   count_inc     1-cycle increment pulse
//   count_clr     clear: pulse on wrap, level while IDLE
//   anim_trigger  1-cycle pulse starting the LED animation
//   anim_active   high throughout CELEBRATE
//   state_o       encoded FSM state
module count_sequencer_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned AUTO_TICK_CYC = 12_500_000,
  parameter int unsigned CELEBRATE_CYC = 100_000_000,
  parameter int unsigned COUNT_MAX     = 150
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button_raw,
  input  logic               run,
  input  logic               mode_sel,
  input  logic [COUNT_W-1:0] count,
  output logic               count_inc,
  output logic               count_clr,
  output logic               anim_trigger,
  output logic               anim_active,
  output logic [1:0]         state_o
);

  localparam int unsigned TickW = (AUTO_TICK_CYC > 1) ? $clog2(AUTO_TICK_CYC) : 1;
  localparam int unsigned CelW  = (CELEBRATE_CYC > 1) ? $clog2(CELEBRATE_CYC) : 1;

  seq_state_t       state_q, state_d, run_state;
  logic [TickW-1:0] tick_q, tick_d;
  logic [CelW-1:0]  cel_q, cel_d;
  logic             inc_q, inc_d;
  logic             clr_q, clr_d;
  logic             trig_q, trig_d;
  logic             active_q, active_d;
  logic             press_evt, tick_evt, evt, terminal;

  button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .button_raw_i (button_raw),
    .press_evt_o  (press_evt)
  );

  always_comb begin
    run_state = mode_sel ? AUTO : MANUAL;
    tick_evt  = (state_q == AUTO) && (tick_q == TickW'(AUTO_TICK_CYC - 1));
    evt       = (state_q == MANUAL) ? press_evt :
                (state_q == AUTO)   ? tick_evt  : 1'b0;
    // Anything at or above the terminal count (including a corrupt value) wraps.
    terminal  = (count >= COUNT_W'(COUNT_MAX));

    state_d = state_q;
    cel_d   = '0;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    trig_d  = 1'b0;

    if (!run) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = run_state;
        MANUAL, AUTO: begin
          if (evt && terminal) begin
            clr_d   = 1'b1;
            trig_d  = 1'b1;
            state_d = CELEBRATE;
          end else begin
            inc_d   = evt;
            state_d = run_state;
          end
        end
        CELEBRATE: begin
          if (cel_q == CelW'(CELEBRATE_CYC - 1)) begin
            state_d = run_state;
          end else begin
            cel_d = cel_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Tick timer only runs while staying in AUTO; any exit or entry restarts it at 0.
    tick_d = ((state_q == AUTO) && (state_d == AUTO) && !tick_evt) ? tick_q + 1'b1 : '0;

    // Outputs are registered against the next state so they line up with state_o.
    clr_d    = clr_d | (state_d == IDLE);
    active_d = (state_d == CELEBRATE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      cel_q    <= '0;
      inc_q    <= 1'b0;
      clr_q    <= 1'b1;
      trig_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      cel_q    <= cel_d;
      inc_q    <= inc_d;
      clr_q    <= clr_d;
      trig_q   <= trig_d;
      active_q <= active_d;
    end
  end

  assign count_inc    = inc_q;
  assign count_clr    = clr_q;
  assign anim_trigger = trig_q;
  assign anim_active  = active_q;
  assign state_o      = state_q;

endmodule
